// File: rtl/branch_pkg.sv
// Shared constants and types for the branch resolution unit and its
// condition evaluator.
package branch_pkg;

  localparam logic [3:0] COND_NE  = 4'h0;
  localparam logic [3:0] COND_EQ  = 4'h1;
  localparam logic [3:0] COND_GT  = 4'h2;
  localparam logic [3:0] COND_LT  = 4'h3;
  localparam logic [3:0] COND_GE  = 4'h4;
  localparam logic [3:0] COND_LE  = 4'h5;
  localparam logic [3:0] COND_VS  = 4'h6;
  localparam logic [3:0] COND_AL  = 4'h7;
  localparam logic [3:0] COND_HI  = 4'h8;
  localparam logic [3:0] COND_LO  = 4'h9;
  localparam logic [3:0] COND_HS  = 4'hA;
  localparam logic [3:0] COND_LS  = 4'hB;
  localparam logic [3:0] COND_VC  = 4'hC;
  localparam logic [3:0] COND_SGT = 4'hD;
  localparam logic [3:0] COND_SLT = 4'hE;
  localparam logic [3:0] COND_NV  = 4'hF;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic [0:0] {INIT, RUN} state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: 4-bit condition code plus ALU
// flags to a taken/not-taken decision.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] res_cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       C,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (res_cond)
      COND_NE:  taken = ~Z;
      COND_EQ:  taken = Z;
      COND_GT:  taken = ~(Z | N);
      COND_LT:  taken = N;
      COND_GE:  taken = Z | ~N;
      COND_LE:  taken = N | Z;
      COND_VS:  taken = V;
      COND_AL:  taken = 1'b1;
      COND_HI:  taken = C & ~Z;
      COND_LO:  taken = ~C;
      COND_HS:  taken = C;
      COND_LS:  taken = ~C | Z;
      COND_VC:  taken = ~V;
      COND_SGT: taken = ~Z & (N ~^ V);
      COND_SLT: taken = N ^ V;
      COND_NV:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution with bimodal prediction table, registered outcome,
// mispredict pulse and saturating mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [PC_W-1:0]  res_pc,
  input  logic [3:0]       res_cond,
  input  logic             res_pred_taken,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  input  logic             C,
  output logic             brch,
  output logic             brch_valid,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic             init_busy
);

  localparam int unsigned            Entries = 2 ** BHT_IDX_W;
  localparam logic [BHT_IDX_W-1:0]   IdxMax  = '1;
  localparam logic [BHT_IDX_W-1:0]   IdxOne  = BHT_IDX_W'(1);
  localparam logic [CNT_W-1:0]       CntMax  = '1;
  localparam logic [CNT_W-1:0]       CntOne  = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [BHT_IDX_W-1:0]   init_idx_q, init_idx_d;
  logic [1:0]             bht_q [Entries];
  logic [BHT_IDX_W-1:0]   pred_idx, res_idx;
  logic [1:0]             ctr_cur, ctr_upd;
  logic                   taken, res_act;
  logic                   brch_q, brch_valid_q, mispredict_q;
  logic                   mispredict_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_W-1:BHT_IDX_W+2], pred_pc[1:0],
                            res_pc[PC_W-1:BHT_IDX_W+2], res_pc[1:0]};

  branch_cond_eval u_cond_eval (
    .res_cond (res_cond),
    .Z        (Z),
    .N        (N),
    .V        (V),
    .C        (C),
    .taken    (taken)
  );

  assign pred_idx   = pred_pc[BHT_IDX_W+1:2];
  assign res_idx    = res_pc[BHT_IDX_W+1:2];
  assign init_busy  = (state_q == INIT);
  assign pred_taken = ~init_busy & bht_q[pred_idx][1];
  assign res_act    = ~init_busy & res_valid;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == INIT) begin
      init_idx_d = init_idx_q + IdxOne;
      if (init_idx_q == IdxMax) state_d = RUN;
    end
  end

  always_comb begin
    ctr_cur = bht_q[res_idx];
    ctr_upd = ctr_cur;
    if (taken && ctr_cur != CTR_ST) begin
      ctr_upd = ctr_cur + 2'd1;
    end else if (!taken && ctr_cur != CTR_SNT) begin
      ctr_upd = ctr_cur - 2'd1;
    end
  end

  // Count on the same edge that raises the pulse so both appear together.
  always_comb begin
    mispredict_d = res_act & (taken != res_pred_taken);
    cnt_d        = cnt_q;
    if (mispredict_d && cnt_q != CntMax) cnt_d = cnt_q + CntOne;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Table has no reset; the init sweep restores every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        bht_q[init_idx_q] <= CTR_WNT;
      end else if (res_valid) begin
        bht_q[res_idx] <= ctr_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brch_q       <= 1'b0;
      brch_valid_q <= 1'b0;
      mispredict_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (res_act) brch_q <= taken;
      brch_valid_q <= res_act;
      mispredict_q <= mispredict_d;
      cnt_q        <= cnt_d;
    end
  end

  assign brch           = brch_q;
  assign brch_valid     = brch_valid_q;
  assign mispredict     = mispredict_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: init sweep, BHT saturation,
// condition decode, same-index collision, counter saturation, mid-sweep reset.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [3:0]  res_cond;
  logic        res_pred_taken;
  logic        Z, N, V, C;

  logic        pred_taken, brch, brch_valid, mispredict, init_busy;
  logic [15:0] mispredict_cnt;
  logic        pred_taken4, brch4, brch_valid4, mispredict4, init_busy4;
  logic [3:0]  mispredict_cnt4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_cnt4 = 0;

  always #5 clk = ~clk;

  branch_resolve_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_cond       (res_cond),
    .res_pred_taken (res_pred_taken),
    .Z              (Z),
    .N              (N),
    .V              (V),
    .C              (C),
    .brch           (brch),
    .brch_valid     (brch_valid),
    .mispredict     (mispredict),
    .mispredict_cnt (mispredict_cnt),
    .init_busy      (init_busy)
  );

  branch_resolve_unit #(.CNT_W(4)) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken4),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_cond       (res_cond),
    .res_pred_taken (res_pred_taken),
    .Z              (Z),
    .N              (N),
    .V              (V),
    .C              (C),
    .brch           (brch4),
    .brch_valid     (brch_valid4),
    .mispredict     (mispredict4),
    .mispredict_cnt (mispredict_cnt4),
    .init_busy      (init_busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    pred_pc = pc;
    #1;
    check(tag, {31'b0, pred_taken}, {31'b0, exp});
  endtask

  // One resolution cycle, then check registered outputs on both instances.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic [3:0] cond,
                         input logic [3:0] znvc, input logic pred, input logic exp_brch);
    res_valid      = 1'b1;
    res_pc         = pc;
    res_cond       = cond;
    {Z, N, V, C}   = znvc;
    res_pred_taken = pred;
    step();
    res_valid = 1'b0;
    if (exp_brch != pred) begin
      exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    check({tag, ".brch"}, {31'b0, brch}, {31'b0, exp_brch});
    check({tag, ".valid"}, {31'b0, brch_valid}, 32'd1);
    check({tag, ".mp"}, {31'b0, mispredict}, {31'b0, exp_brch != pred});
    check({tag, ".cnt"}, {16'b0, mispredict_cnt}, exp_cnt);
    check({tag, ".cnt4"}, {28'b0, mispredict_cnt4}, exp_cnt4);
  endtask

  // Run until the sweep ends, counting busy cycles; optionally pulse res_valid.
  task automatic wait_sweep(input string tag, input int pulse_at);
    int n = 0;
    while (init_busy && n < 200) begin
      res_valid = (n == pulse_at);
      res_pc    = 32'h204;
      res_cond  = COND_AL;
      res_pred_taken = 1'b0;
      check_pred({tag, ".pred_busy"}, $urandom, 1'b0);
      step();
      if (n == pulse_at) begin
        check({tag, ".pulse_valid"}, {31'b0, brch_valid}, 32'd0);
        check({tag, ".pulse_mp"}, {31'b0, mispredict}, 32'd0);
        check({tag, ".pulse_cnt"}, {16'b0, mispredict_cnt}, 32'd0);
      end
      n++;
    end
    res_valid = 1'b0;
    check({tag, ".busy_cycles"}, n, 64);
  endtask

  initial begin
    rst = 1'b1; pred_pc = '0; res_valid = 1'b0; res_pc = '0; res_cond = '0;
    res_pred_taken = 1'b0; {Z, N, V, C} = 4'b0;

    // Reset and full init sweep.
    step();
    rst = 1'b0;
    check("rst.busy", {31'b0, init_busy}, 32'd1);
    check("rst.brch", {31'b0, brch}, 32'd0);
    check("rst.valid", {31'b0, brch_valid}, 32'd0);
    check("rst.mp", {31'b0, mispredict}, 32'd0);
    check("rst.cnt", {16'b0, mispredict_cnt}, 32'd0);
    wait_sweep("init", -1);
    check_pred("post_init.100", 32'h100, 1'b0);
    check_pred("post_init.204", 32'h204, 1'b0);
    check_pred("post_init.0fc", 32'h0fc, 1'b0);

    // Taken streak on 0x100: 01->10->11->11, then back down.
    pred_pc = 32'h100;
    resolve("eq1", 32'h100, COND_EQ, 4'b1000, 1'b0, 1'b1);
    check_pred("eq1.pred", 32'h100, 1'b1);
    resolve("eq2", 32'h100, COND_EQ, 4'b1000, 1'b1, 1'b1);
    resolve("eq3", 32'h100, COND_EQ, 4'b1000, 1'b1, 1'b1);
    check_pred("eq3.pred", 32'h100, 1'b1);
    step();
    check("idle.valid", {31'b0, brch_valid}, 32'd0);
    check("idle.mp", {31'b0, mispredict}, 32'd0);
    check("idle.brch_hold", {31'b0, brch}, 32'd1);
    resolve("ne_eq4", 32'h100, COND_EQ, 4'b0000, 1'b1, 1'b0);
    check_pred("sat.pred10", 32'h100, 1'b1);
    resolve("ne_eq5", 32'h100, COND_EQ, 4'b0000, 1'b0, 1'b0);
    check_pred("sat.pred01", 32'h100, 1'b0);

    // Condition decode spot checks (flags are {Z,N,V,C}).
    resolve("hi", 32'h010, COND_HI, 4'b0001, 1'b0, 1'b1);
    resolve("ls", 32'h010, COND_LS, 4'b0001, 1'b0, 1'b0);
    resolve("sgt", 32'h010, COND_SGT, 4'b0110, 1'b1, 1'b1);
    resolve("slt", 32'h010, COND_SLT, 4'b0100, 1'b1, 1'b1);
    resolve("ge", 32'h010, COND_GE, 4'b0100, 1'b0, 1'b0);
    resolve("gt", 32'h010, COND_GT, 4'b0000, 1'b1, 1'b1);
    resolve("lo", 32'h010, COND_LO, 4'b0000, 1'b1, 1'b1);
    resolve("nv", 32'h010, COND_NV, 4'b1111, 1'b0, 1'b0);
    resolve("vc", 32'h010, COND_VC, 4'b0010, 1'b0, 1'b0);

    // Same-index collision: prediction sees pre-update counter.
    pred_pc = 32'h204;
    res_valid = 1'b1; res_pc = 32'h204; res_cond = COND_EQ; {Z, N, V, C} = 4'b1000;
    res_pred_taken = 1'b0;
    #1;
    check("coll.before", {31'b0, pred_taken}, 32'd0);
    step();
    res_valid = 1'b0;
    exp_cnt++; exp_cnt4++;
    check("coll.after", {31'b0, pred_taken}, 32'd1);

    // Drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) resolve("sat_mp", 32'h010, COND_AL, 4'b0000, 1'b0, 1'b1);
    check("sat.cnt4", {28'b0, mispredict_cnt4}, 32'd15);
    step();
    check("sat.cnt4_hold", {28'b0, mispredict_cnt4}, 32'd15);

    // Reset from RUN, then again at sweep index 30.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("mid.busy30", {31'b0, init_busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid.cnt", {16'b0, mispredict_cnt}, 32'd0);
    check("mid.cnt4", {28'b0, mispredict_cnt4}, 32'd0);
    check("mid.brch", {31'b0, brch}, 32'd0);
    wait_sweep("mid", 5);
    check_pred("mid.pred204", 32'h204, 1'b0);
    check_pred("mid.pred100", 32'h100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
